// File: rtl/audio_pkg.sv
// Shared audio-chain definitions: sample width helper and I2S channel codes.
package audio_pkg;

  // Word-select level for each I2S channel
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // Sample width in bits for a given byte count
  function automatic int unsigned sample_width(input int unsigned word_bytes);
    return 8 * word_bytes;
  endfunction

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Valid/ready sample stream between audio-chain stages.
interface audio_i2s_tx_if
  import audio_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 2
) ();

  localparam int unsigned W = sample_width(WORD_BYTES);

  logic         tvalid;
  logic [W-1:0] tdata;
  logic         tready;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/audio_bclk_gen.sv
// I2S bit-clock generator: sclk toggles every CLK_DIV clk cycles.
// rise_c/fall_c flag the clk edge on which sclk is about to rise/fall,
// so consumers can update state on the same edge sclk changes.
module audio_bclk_gen #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  output logic sclk,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 2) begin : g_div_check
    $error("audio_bclk_gen: CLK_DIV must be at least 2");
  end

  logic [DIV_W-1:0] div_cnt;
  logic             tc_c;

  assign tc_c   = (div_cnt == DIV_LAST);
  assign rise_c = tc_c && !sclk;
  assign fall_c = tc_c && sclk;

  // Divider counter and bit-clock toggle at terminal count
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (tc_c) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// Stream-to-I2S transmitter: one mono sample per frame, sent MSB-first
// on both channels, with an underrun (zero) frame when no sample is held.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 2,
  parameter int unsigned CLK_DIV    = 8
) (
  input  logic           clk,
  input  logic           reset,
  audio_i2s_tx_if.slave  s,
  output logic           sclk,
  output logic           lrclk,
  output logic           sdata,
  output logic           frame_start,
  output logic           underrun
);

  localparam int unsigned W      = sample_width(WORD_BYTES);
  localparam int unsigned SLOTS  = 2 * W;
  localparam int unsigned SLOT_W = $clog2(SLOTS);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOTS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LR_UP = SLOT_W'(W - 1);

  logic [W-1:0]      hold;
  logic              hold_full;
  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] slot_next_c;
  logic [SLOTS-1:0]  shreg;
  logic              fall_c;
  logic              rise_unused_c;
  logic              xfer_c;
  logic              load_c;

  // Bit clock; the rising strobe is only needed by receive-side users
  audio_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk (
    .clk    (clk),
    .reset  (reset),
    .sclk   (sclk),
    .rise_c (rise_unused_c),
    .fall_c (fall_c)
  );

  assign s.tready    = !hold_full && !reset;
  assign xfer_c      = s.tvalid && s.tready;
  assign load_c      = fall_c && (slot == SLOT_LAST);
  assign slot_next_c = (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);

  // Single-entry hold register; a load empties it before a same-edge transfer refills it
  always_ff @(posedge clk) begin
    if (reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      if (load_c) begin
        hold_full <= 1'b0;
      end
      if (xfer_c) begin
        hold      <= s.tdata;
        hold_full <= 1'b1;
      end
    end
  end

  // Slot counter, frame shift register and registered serial outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      slot        <= SLOT_LAST;
      shreg       <= '0;
      sdata       <= 1'b0;
      lrclk       <= CH_LEFT;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (fall_c) begin
        slot <= slot_next_c;
        if (load_c) begin
          frame_start <= 1'b1;
          if (hold_full) begin
            shreg <= {hold, hold};
            sdata <= hold[W-1];
          end else begin
            shreg    <= '0;
            sdata    <= 1'b0;
            underrun <= 1'b1;
          end
        end else begin
          shreg <= shreg << 1;
          sdata <= shreg[SLOTS-2];
        end
        // Word select leads each channel's MSB by one slot
        if (slot_next_c == SLOT_LR_UP) begin
          lrclk <= CH_RIGHT;
        end else if (slot_next_c == SLOT_LAST) begin
          lrclk <= CH_LEFT;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: scoreboard of accepted samples vs. serial output.
module tb_audio_i2s_tx;
  import audio_pkg::*;

  localparam int unsigned WB = 2;
  localparam int W     = int'(sample_width(WB));
  localparam int DIV   = 2;
  localparam int FRAME = 2 * W * 2 * DIV;

  logic clk = 1'b0;
  logic reset;
  logic sclk0, lr0, sd0, fs0, ur0;
  logic sclk1, lr1, sd1, fs1, ur1;
  logic sclk2, lr2, sd2, fs2, ur2;

  audio_i2s_tx_if #(.WORD_BYTES(WB)) if0 ();
  audio_i2s_tx_if #(.WORD_BYTES(WB)) if1 ();
  audio_i2s_tx_if #(.WORD_BYTES(WB)) if2 ();

  audio_i2s_tx #(.WORD_BYTES(WB), .CLK_DIV(DIV)) dut0 (
    .clk(clk), .reset(reset), .s(if0), .sclk(sclk0), .lrclk(lr0),
    .sdata(sd0), .frame_start(fs0), .underrun(ur0));
  audio_i2s_tx #(.WORD_BYTES(WB), .CLK_DIV(3)) dut1 (
    .clk(clk), .reset(reset), .s(if1), .sclk(sclk1), .lrclk(lr1),
    .sdata(sd1), .frame_start(fs1), .underrun(ur1));
  audio_i2s_tx #(.WORD_BYTES(WB), .CLK_DIV(5)) dut2 (
    .clk(clk), .reset(reset), .s(if2), .sclk(sclk2), .lrclk(lr2),
    .sdata(sd2), .frame_start(fs2), .underrun(ur2));

  always #5 clk = ~clk;

  // Capture handshake and reset as seen at each active edge
  logic         acc_flag;
  logic [W-1:0] acc_data;
  logic         rst_at_edge;
  always @(posedge clk) begin
    acc_flag    <= if0.tvalid && if0.tready;
    acc_data    <= if0.tdata;
    rst_at_edge <= reset;
  end

  logic [W-1:0] samp_q[$];
  logic [1:0]   bit_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_fs = -1;
  logic psclk = 1'b0;

  // Reference model step, run once per cycle at the falling clk edge
  task automatic mon();
    logic [W-1:0] smp;
    logic [1:0]   exp_b;
    logic         lr_b;
    cyc++;
    if (rst_at_edge) begin
      samp_q.delete();
      bit_q.delete();
      last_fs = -1;
      psclk = sclk0;
      return;
    end
    if (fs0) begin
      n_cmp++;
      if (ur0 !== (samp_q.size() == 0)) begin
        n_err++;
        $display("FAIL sb_underrun: got %0b want %0b at cyc %0d", ur0, samp_q.size() == 0, cyc);
      end
      if (samp_q.size() > 0) smp = samp_q.pop_front();
      else smp = '0;
      if (last_fs >= 0) begin
        n_cmp++;
        if (cyc - last_fs != FRAME) begin
          n_err++;
          $display("FAIL sb_frame_period: got %0d want %0d", cyc - last_fs, FRAME);
        end
      end
      last_fs = cyc;
      for (int k = 0; k < 2 * W; k++) begin
        lr_b = (k >= W - 1) && (k <= 2 * W - 2);
        bit_q.push_back({lr_b, smp[W-1-(k%W)]});
      end
    end else begin
      n_cmp++;
      if (ur0 !== 1'b0) begin
        n_err++;
        $display("FAIL sb_stray_underrun: got %0b want 0 at cyc %0d", ur0, cyc);
      end
    end
    if (acc_flag) samp_q.push_back(acc_data);
    if (sclk0 && !psclk && bit_q.size() > 0) begin
      exp_b = bit_q.pop_front();
      n_cmp++;
      if ({lr0, sd0} !== exp_b) begin
        n_err++;
        $display("FAIL sb_slot_bits: got lr/sd %b want %b at cyc %0d", {lr0, sd0}, exp_b, cyc);
      end
    end
    psclk = sclk0;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    if0.tvalid = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if ({sclk0, lr0, sd0, fs0, ur0, if0.tready} !== 6'b0) begin
      n_err++;
      $display("FAIL %s_outputs: got sclk/lr/sd/fs/ur/rdy %b want 000000", tag,
               {sclk0, lr0, sd0, fs0, ur0, if0.tready});
    end
  endtask

  task automatic test_reset();
    logic exp_sclk, exp_fs;
    reset = 1'b1;
    if0.tvalid = 1'b1;
    if0.tdata = 16'hFFFF;
    repeat (3) tick();
    check_reset_outputs("reset");
    if0.tvalid = 1'b0;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (if0.tready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_cycle0: got %b want 1", if0.tready);
    end
    for (int t = 1; t <= 2 * DIV; t++) begin
      tick();
      exp_sclk = (t >= DIV) && (t < 2 * DIV);
      exp_fs = (t == 2 * DIV);
      n_cmp++;
      if (sclk0 !== exp_sclk || fs0 !== exp_fs) begin
        n_err++;
        $display("FAIL reset_release_timing t=%0d: got sclk/fs %b%b want %b%b", t, sclk0, fs0, exp_sclk, exp_fs);
      end
    end
    n_cmp++;
    if (ur0 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_drop_xfer: got underrun %b want 1", ur0);
    end
  endtask

  task automatic test_single_sample();
    int nfs = 0, nur = 0;
    do_reset(2);
    if0.tvalid = 1'b1;
    if0.tdata = 16'hA55A;
    tick();
    n_cmp++;
    if (acc_flag !== 1'b1) begin
      n_err++;
      $display("FAIL single_accept: got %b want 1", acc_flag);
    end
    if0.tvalid = 1'b0;
    repeat (2 * FRAME + 8) begin
      tick();
      if (fs0) nfs++;
      if (ur0) nur++;
    end
    n_cmp++;
    if (nfs != 3 || nur != 2) begin
      n_err++;
      $display("FAIL single_frames: got fs=%0d ur=%0d want fs=3 ur=2", nfs, nur);
    end
  endtask

  task automatic test_no_input();
    int nfs = 0, nur = 0, nmis = 0;
    do_reset(2);
    repeat (2 * FRAME + 2 * DIV) begin
      tick();
      if (fs0) nfs++;
      if (ur0) nur++;
      if (fs0 !== ur0) nmis++;
    end
    n_cmp++;
    if (nfs != 3 || nur != 3 || nmis != 0) begin
      n_err++;
      $display("FAIL no_input: got fs=%0d ur=%0d misaligned=%0d want 3/3/0", nfs, nur, nmis);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] list[5];
    int idx = 0, nacc = 0, nur = 0, low_run = 0, gaps = 0;
    list[0] = 16'h7FFF; list[1] = 16'h8000; list[2] = 16'h1357;
    list[3] = 16'hC0DE; list[4] = 16'h0001;
    do_reset(2);
    if0.tvalid = 1'b1;
    if0.tdata = list[0];
    repeat (5 * FRAME) begin
      tick();
      if (ur0) nur++;
      if (acc_flag) begin
        nacc++;
        idx++;
        if0.tdata = list[idx % 5];
      end
      if (!if0.tready) begin
        low_run++;
      end else if (low_run > 0) begin
        if (gaps > 0) begin
          n_cmp++;
          if (low_run != FRAME - 1) begin
            n_err++;
            $display("FAIL b2b_ready_gap: got %0d want %0d", low_run, FRAME - 1);
          end
        end
        gaps++;
        low_run = 0;
      end
    end
    if0.tvalid = 1'b0;
    n_cmp++;
    if (nacc != 6 || nur != 0) begin
      n_err++;
      $display("FAIL b2b_counts: got acc=%0d ur=%0d want acc=6 ur=0", nacc, nur);
    end
  endtask

  task automatic test_transfer_on_load();
    do_reset(2);
    repeat (2 * DIV - 1) tick();
    if0.tvalid = 1'b1;
    if0.tdata = 16'h1234;
    tick();
    n_cmp++;
    if ({fs0, ur0, acc_flag} !== 3'b111) begin
      n_err++;
      $display("FAIL load_xfer_same_edge: got fs/ur/acc %b want 111", {fs0, ur0, acc_flag});
    end
    if0.tvalid = 1'b0;
    repeat (FRAME) tick();
    n_cmp++;
    if ({fs0, ur0} !== 2'b10) begin
      n_err++;
      $display("FAIL load_xfer_next_frame: got fs/ur %b want 10", {fs0, ur0});
    end
    repeat (FRAME) tick();
  endtask

  task automatic test_reset_mid_frame();
    do_reset(2);
    if0.tvalid = 1'b1;
    if0.tdata = 16'h0F0F;
    tick();
    if0.tdata = 16'hBEEF;
    repeat (4) tick();
    n_cmp++;
    if (acc_flag !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_second_accept: got %b want 1", acc_flag);
    end
    if0.tvalid = 1'b0;
    repeat (29) tick();
    n_cmp++;
    if (if0.tready !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_hold_full: got ready %b want 0", if0.tready);
    end
    reset = 1'b1;
    tick();
    check_reset_outputs("midreset");
    reset = 1'b0;
    repeat (2 * DIV) tick();
    n_cmp++;
    if ({fs0, ur0} !== 2'b11) begin
      n_err++;
      $display("FAIL midreset_first_load: got fs/ur %b want 11", {fs0, ur0});
    end
    repeat (FRAME) tick();
  endtask

  task automatic test_divider_sweep();
    int run[2];
    logic seen[2];
    logic [1:0] sc, sd, lr, psc, psd, plr;
    int div;
    if1.tvalid = 1'b1; if1.tdata = 16'hA5C3;
    if2.tvalid = 1'b1; if2.tdata = 16'h3C5A;
    do_reset(2);
    psc = {sclk2, sclk1}; psd = {sd2, sd1}; plr = {lr2, lr1};
    run[0] = 0; run[1] = 0; seen[0] = 1'b0; seen[1] = 1'b0;
    repeat (600) begin
      tick();
      sc = {sclk2, sclk1}; sd = {sd2, sd1}; lr = {lr2, lr1};
      for (int d = 0; d < 2; d++) begin
        div = (d == 0) ? 3 : 5;
        if (sc[d] !== psc[d]) begin
          if (seen[d]) begin
            n_cmp++;
            if (run[d] != div) begin
              n_err++;
              $display("FAIL sweep_half_period div=%0d: got %0d want %0d", div, run[d], div);
            end
          end
          seen[d] = 1'b1;
          run[d] = 1;
        end else begin
          run[d]++;
        end
        if (sd[d] !== psd[d] || lr[d] !== plr[d]) begin
          n_cmp++;
          if (!(psc[d] === 1'b1 && sc[d] === 1'b0)) begin
            n_err++;
            $display("FAIL sweep_change_edge div=%0d: got sclk %b->%b want 1->0", div, psc[d], sc[d]);
          end
        end
      end
      psc = sc; psd = sd; plr = lr;
    end
    if1.tvalid = 1'b0;
    if2.tvalid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    if0.tvalid = 1'b0; if0.tdata = '0;
    if1.tvalid = 1'b0; if1.tdata = '0;
    if2.tvalid = 1'b0; if2.tdata = '0;
    test_reset();
    test_single_sample();
    test_no_input();
    test_back_to_back();
    test_transfer_on_load();
    test_reset_mid_frame();
    test_divider_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Stream-to-I2S transmitter at the output end of the audio chain. Consumes mono samples over an AXI-Stream-style valid/ready handshake, as produced by the audio oscillator and downstream filter/decimator stages. Serialises each sample MSB-first onto both I2S channels with internally generated bit clock and word select, so the chain can drive an external DAC directly. Paces upstream via `s_tready`: one sample per I2S frame.

## Interface
- `WORD_BYTES`, 2: sample width in bytes. Define `W = 8*WORD_BYTES`.
- `CLK_DIV`, 8: `clk` cycles per half `sclk` period. Must be ≥2; elaborate-time error otherwise.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high. Clock is `clk`.
- `s_tvalid` in 1: upstream sample valid.
- `s_tdata` in W: sample, passed to the wire bit-exact with no format conversion.
- `s_tready` out 1: sample accepted when `s_tvalid & s_tready` at a `clk` edge.
- `sclk` out 1: I2S bit clock.
- `lrclk` out 1: word select. 0 = left, 1 = right.
- `sdata` out 1: serial data.
- `frame_start` out 1: one-cycle pulse on each frame load.
- `underrun` out 1: one-cycle pulse when a frame loads with no sample held.

## Operation
- **Hold register:** one entry `hold` plus flag `hold_full`.
  - `s_tready = !hold_full && !reset`.
  - On a transfer: `hold <= s_tdata`, `hold_full <= 1`.
- **Divider:** `div_cnt` counts 0..CLK_DIV-1. At terminal count it wraps and toggles `sclk`.
  - A 1→0 toggle is a slot boundary.
  - Bit period is `2*CLK_DIV` clks; frame is 2W slots.
- **Slot counter:** `slot` 0..2W-1, advances at each slot boundary and wraps 2W-1→0.
- **Entering slot 0 (load):**
  - If `hold_full`: shift register ← `hold`, `hold_full <= 0`.
  - Else: shift register ← 0 and `underrun` pulses.
  - `frame_start` pulses in both cases.
- **Data per slot:**
  - Slot k in 0..W-1: `sdata` = sample bit W-1-k (left).
  - Slot W+k: `sdata` = the same sample's bit W-1-k (right). The mono sample is duplicated on both channels.
- **Word select:** `lrclk` goes 1 entering slot W-1 and 0 entering slot 2W-1. It leads the MSB of each channel by one slot, per standard I2S.
- **Change edges:** `sdata`/`lrclk` change only at slot boundaries (`sclk` falling), so the DAC samples them on `sclk` rising.
- **Load and transfer in the same cycle** (hold empty): the load sees an empty hold, so the frame is zero and `underrun` pulses. The transferred sample lands in `hold` for the next frame.
- **Upstream stall:** `s_tvalid` low indefinitely gives repeated zero frames with an `underrun` pulse each frame. Timing continues unchanged.

## Timing
- **Reset values:**
  - Outputs: `sclk`=0, `lrclk`=0, `sdata`=0, `s_tready`=0 during reset, `frame_start`=0, `underrun`=0.
  - Internal: `div_cnt`=0, `slot`=2W-1, `hold_full`=0.
  - Reset applies on any cycle, mid-frame included. It aborts the frame and discards the held sample; a transfer in a reset cycle is dropped.
- **After reset (cycle 0 = first cycle with reset low):**
  - `s_tready`=1 from cycle 0.
  - `sclk` rises at edge CLK_DIV.
  - `sclk` falls at edge 2*CLK_DIV: first load, `frame_start`, `sdata` = MSB.
  - First frame underruns unless a sample was accepted before edge 2*CLK_DIV.
- Loads recur every `2W*2*CLK_DIV` clks.
- Latency from accept to MSB on `sdata` is at most one frame plus `2*CLK_DIV` clks.
- `s_tready` rises the cycle after each load that empties `hold`.
- All outputs are registered; `s_tready` is derived from `hold_full` and `reset` only.

## Structure
- **Shared package `audio_pkg`:** `sample_width(WORD_BYTES)` function, I2S channel constants `CH_LEFT=0`/`CH_RIGHT=1`.
- **Sub-module `audio_bclk_gen`:** parameter CLK_DIV. Outputs `sclk` plus one-cycle `rise`/`fall` strobes. Reused by a future I2S receiver.
- The top level holds the hold register, slot counter and shift register.

## Test plan
- **Single sample:** WORD_BYTES=2, CLK_DIV=2; 0xA55A offered before first load.
  - `sdata` over slots 0..15 = 1010010101011010, repeated over slots 16..31.
  - `lrclk` high over slots 15..30.
- **No input:** `s_tvalid`=0 throughout → every frame all zeros, `underrun` pulses once per 128 clks (CLK_DIV=2, W=16). `frame_start` pulses in the same cycles.
- **Back-to-back:** `s_tvalid` held high with 0x7FFF, 0x8000, ....
  - Exactly one accept per frame, no underrun after the first loaded frame.
  - `s_tready` low for exactly one frame minus one cycle between accepts.
- **Transfer on load cycle:** hold empty, transfer 0x1234 coincident with `frame_start` → that frame zeros with `underrun`=1. Next frame carries 0x1234.
- **Reset mid-frame:** reset asserted for 1 cycle at slot 7 with `hold_full`=1 → outputs and `s_tready` per reset values. Held sample never transmitted; first load again `2*CLK_DIV` clks after release.
- **Divider sweep:** CLK_DIV=3 and 5 → `sclk` period 6/10 clks, 50% duty. `sdata` and `lrclk` transitions coincide only with `sclk` falling.
